// File: rtl/muldiv_pkg.sv
// Shared decode constants, FSM encoding and sign helpers for the iterative RV32M unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Result sign: remainder follows the dividend, everything else is sign_a ^ sign_b.
  function automatic logic neg_result(input logic [2:0] f3, input logic sa, input logic sb);
    return (f3[2] && f3[1]) ? sa : (sa ^ sb);
  endfunction

endpackage

// File: rtl/muldiv_iter_special.sv
// Combinational detection of div-by-zero / signed overflow, plus zero-operand and
// small-dividend early-out when MULDIV_EARLY_OUT_EN is defined.
module muldiv_special
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            hit,
  output logic [XLEN-1:0] value
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic is_div, is_rem, is_sdiv;
  assign is_div  = funct3[2];
  assign is_rem  = funct3[2] & funct3[1];
  assign is_sdiv = funct3[2] & ~funct3[0];

`ifdef MULDIV_EARLY_OUT_EN
  logic            sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  assign sa    = signed_a(funct3) & a[XLEN-1];
  assign sb    = signed_b(funct3) & b[XLEN-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
`endif

  always_comb begin
    hit   = 1'b0;
    value = '0;
    if (is_div && (b == '0)) begin
      hit   = 1'b1;
      value = is_rem ? a : '1;
    end else if (is_sdiv && (a == MIN_NEG) && (b == '1)) begin
      hit   = 1'b1;
      value = is_rem ? '0 : a;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!is_div && ((a == '0) || (b == '0))) begin
      hit   = 1'b1;
      value = '0;
    end else if (is_div && (abs_a < abs_b)) begin
      hit   = 1'b1;
      value = is_rem ? a : '0;
    end
`endif
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, UNROLL bits/cycle.
// Optional build macro: MULDIV_EARLY_OUT_EN (zero-operand / small-dividend short path).
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [1:0]      i_ALUOp,
  input  logic [6:0]      i_Funct7,
  input  logic [2:0]      i_Funct3,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_Flush,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_Result,
  output logic            o_Illegal,
  output logic            o_Busy
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  state_t            state_q, state_n;
  logic [2*XLEN-1:0] acc_q, step_acc, prod;
  logic [XLEN-1:0]   opnd_q, result_q, fix_val;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q, illegal_q;

  logic              accept, legal, sa_in, sb_in, spec_hit;
  logic [XLEN-1:0]   abs_a, abs_b, spec_val, quo_fix, rem_fix;
  logic [XLEN:0]     sh, diff, sum;

  assign accept = i_Valid && (state_q == S_IDLE) && !i_Flush;
  assign legal  = (i_ALUOp == ALUOP_R) && (i_Funct7 == F7_MULDIV);
  assign sa_in  = signed_a(i_Funct3) & i_A[XLEN-1];
  assign sb_in  = signed_b(i_Funct3) & i_B[XLEN-1];
  assign abs_a  = sa_in ? -i_A : i_A;
  assign abs_b  = sb_in ? -i_B : i_B;

  muldiv_special #(.XLEN(XLEN)) u_special (
    .funct3 (i_Funct3),
    .a      (i_A),
    .b      (i_B),
    .hit    (spec_hit),
    .value  (spec_val)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (accept) state_n = (!legal || spec_hit) ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CW'(1)) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: if (i_Ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (i_Flush) state_n = S_IDLE;
  end

  // acc holds {hi, lo}: multiply keeps partial product in hi and shifts the multiplier
  // out of lo; divide keeps the partial remainder in hi and shifts quotient bits into lo.
  always_comb begin
    step_acc = acc_q;
    sh       = '0;
    diff     = '0;
    sum      = '0;
    for (int u = 0; u < UNROLL; u++) begin
      if (f3_q[2]) begin
        sh   = step_acc[2*XLEN-1:XLEN-1];
        diff = sh - {1'b0, opnd_q};
        if (!diff[XLEN]) step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
        else             step_acc = {step_acc[2*XLEN-2:0], 1'b0};
      end else begin
        sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opnd_q} : '0);
        step_acc = {sum, step_acc[XLEN-1:1]};
      end
    end
  end

  assign prod    = neg_q ? -acc_q : acc_q;
  assign quo_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    case (f3_q)
      F3_MUL:                       fix_val = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_val = quo_fix;
      default:                      fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (i_Flush) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          f3_q  <= i_Funct3;
          neg_q <= neg_result(i_Funct3, sa_in, sb_in);
          cnt_q <= CW'(N);
          if (!legal) begin
            result_q  <= '0;
            illegal_q <= 1'b1;
          end else if (spec_hit) begin
            result_q  <= spec_val;
            illegal_q <= 1'b0;
          end else begin
            acc_q     <= {{XLEN{1'b0}}, (i_Funct3[2] ? abs_a : abs_b)};
            opnd_q    <= i_Funct3[2] ? abs_b : abs_a;
            illegal_q <= 1'b0;
          end
        end
        S_CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: result_q <= fix_val;
        S_DONE: if (i_Ready) begin
          result_q  <= '0;
          illegal_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_Ready   = (state_q == S_IDLE);
  assign o_Valid   = (state_q == S_DONE);
  assign o_Busy    = (state_q != S_IDLE);
  assign o_Result  = result_q;
  assign o_Illegal = illegal_q;

endmodule
